mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the shared 4:1 4-bit datapath mux.

---
 rtl/mux_rr_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4:1 datapath mux with a registered valid/ready output.
// Optional feature macro: MUX_ARB_LOCK_EN (adds lock[] input and a bounded lock counter).
module mux_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 4,
    parameter int LOCK_MAX = 8,
    localparam int SELW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NREQ-1:0]      lock,
`endif
    input  logic [NREQ*DW-1:0]   data,
    output logic [NREQ-1:0]      ack,
    output logic [SELW-1:0]      select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic                 busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [SELW-1:0]   select_r;
    logic [SELW-1:0]   last_r;
    logic [SELW-1:0]   last_nxt_s;
    logic [SELW-1:0]   sel_nxt_s;
    logic [SELW-1:0]   arb_base_s;
    logic [SELW-1:0]   win_s;
    logic              any_s;
    logic              xfer_s;
    logic              load_s;
    logic              lock_regrant_s;
    logic [DW-1:0]     out_data_r;
    logic              out_valid_r;
    logic              busy_r;
    logic [NREQ-1:0]   ack_s;

    assign xfer_s = (state_r == HOLD) && out_ready;

    // On a transfer the just-served requester becomes lowest priority immediately.
    assign arb_base_s = xfer_s ? select_r : last_r;

    // Wrap-around scan starting just after the priority base.
    always_comb begin : arb_scan
        logic [SELW:0] idx_v;
        win_s = '0;
        any_s = 1'b0;
        idx_v = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_v = {1'b0, arb_base_s} + (SELW+1)'(i);
            if (idx_v >= (SELW+1)'(NREQ)) begin
                idx_v = idx_v - (SELW+1)'(NREQ);
            end else begin
                idx_v = idx_v;
            end
            if (!any_s && req[idx_v[SELW-1:0]]) begin
                win_s = idx_v[SELW-1:0];
                any_s = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    localparam int LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;

    logic [LCW-1:0] lock_cnt_r;
    logic [LCW-1:0] lock_cnt_nxt_s;
    logic           lock_hit_s;

    assign lock_hit_s     = xfer_s && lock[select_r] && req[select_r];
    // The LOCK_MAX-th consecutive locked transfer falls through to normal RR.
    assign lock_regrant_s = lock_hit_s && (lock_cnt_r != LCW'(LOCK_MAX - 1));

    // Lock counter next value: count re-grants, clear on any other transfer.
    always_comb begin
        lock_cnt_nxt_s = lock_cnt_r;
        if (xfer_s) begin
            if (lock_regrant_s) begin
                lock_cnt_nxt_s = lock_cnt_r + LCW'(1);
            end else begin
                lock_cnt_nxt_s = '0;
            end
        end else begin
            lock_cnt_nxt_s = lock_cnt_r;
        end
    end

    // Lock counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_r <= '0;
        end else begin
            lock_cnt_r <= lock_cnt_nxt_s;
        end
    end
`else
    assign lock_regrant_s = 1'b0;
`endif

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            last_r  <= SELW'(NREQ - 1);
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Next-state, grant load and pointer update.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        sel_nxt_s   = select_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s = HOLD;
                    load_s      = 1'b1;
                    sel_nxt_s   = win_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (!out_ready) begin
                    state_nxt_s = HOLD;
                end else if (lock_regrant_s) begin
                    state_nxt_s = HOLD;
                    load_s      = 1'b1;
                    sel_nxt_s   = select_r;
                end else begin
                    last_nxt_s = select_r;
                    if (any_s) begin
                        state_nxt_s = HOLD;
                        load_s      = 1'b1;
                        sel_nxt_s   = win_s;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Captured word, select and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select_r    <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (load_s) begin
                select_r   <= sel_nxt_s;
                out_data_r <= data[sel_nxt_s*DW +: DW];
            end else begin
                select_r   <= select_r;
                out_data_r <= out_data_r;
            end
            out_valid_r <= (state_nxt_s == HOLD);
            busy_r      <= (state_nxt_s == HOLD);
        end
    end

    // Acknowledge pulse for the granted requester on the transfer cycle.
    always_comb begin
        ack_s = '0;
        if (xfer_s) begin
            ack_s[select_r] = 1'b1;
        end else begin
            ack_s = '0;
        end
    end

    assign ack       = ack_s;
    assign select    = select_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed stimulus pushes expected {select,data} beats,
// a negedge monitor pops and compares on every accepted transfer.
module tb_mux_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
`ifdef MUX_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [15:0] data;
    logic [3:0]  ack;
    logic [1:0]  select;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [5:0] exp_q[$];

    mux_rr_arbiter #(.NREQ(4), .DW(4), .LOCK_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef MUX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .data      (data),
        .ack       (ack),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_push(input int s, input int d);
        logic [1:0] s_v;
        logic [3:0] d_v;
        s_v = s[1:0];
        d_v = d[3:0];
        exp_q.push_back({s_v, d_v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted beat must match the next expected grant.
    always @(negedge clk) begin
        logic [5:0] e;
        logic [3:0] ack_exp;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", {30'd0, select}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                ack_exp = 4'b0001 << e[5:4];
                check("xfer_select", {30'd0, select}, {30'd0, e[5:4]});
                check("xfer_data", {28'd0, out_data}, {28'd0, e[3:0]});
                check("xfer_ack", {28'd0, ack}, {28'd0, ack_exp});
            end
        end else begin
            check("ack_idle", {28'd0, ack}, 32'd0);
        end
    end

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        data      = 16'h0000;
        out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        lock      = 4'b0000;
`endif
        #3;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_select", {30'd0, select}, 32'd0);
        check("rst_data", {28'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: all requesting, downstream always ready.
        data = 16'h4321; req = 4'b1111; out_ready = 1'b1;
        exp_push(0, 1); exp_push(1, 2); exp_push(2, 3);
        exp_push(3, 4); exp_push(0, 1); exp_push(1, 2);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fair_valid", {31'd0, out_valid}, 32'd1);
        end
        req = 4'b0000;
        tick();
        check("fair_idle_valid", {31'd0, out_valid}, 32'd0);
        check("fair_idle_busy", {31'd0, busy}, 32'd0);

        // Backpressure: word 4'hA captured and frozen while data[2] changes.
        data = 16'h4A21; req = 4'b0100; out_ready = 1'b0;
        exp_push(2, 10);
        tick();
        for (int i = 0; i < 5; i++) begin
            data[11:8] = 4'(5 + i);
            tick();
            check("bp_hold_data", {28'd0, out_data}, 32'hA);
            check("bp_hold_select", {30'd0, select}, 32'd2);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1; req = 4'b0000;
        tick();
        check("bp_idle_valid", {31'd0, out_valid}, 32'd0);

        // Wrap/skip: serve 3, then only 2, then {0,2} -> 0.
        data = 16'h4521; req = 4'b1000;
        exp_push(3, 4); exp_push(2, 5); exp_push(0, 1);
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0101;
        tick();
        req = 4'b0000;
        tick();
        check("wrap_idle_valid", {31'd0, out_valid}, 32'd0);

        // All requesting with requester 1 locked.
        data = 16'h4321; req = 4'b1111;
`ifdef MUX_ARB_LOCK_EN
        lock = 4'b0010;
        for (int i = 0; i < 8; i++) exp_push(1, 2);
        exp_push(2, 3);
        for (int i = 0; i < 9; i++) tick();
        lock = 4'b0000;
`else
        exp_push(1, 2); exp_push(2, 3); exp_push(3, 4); exp_push(0, 1);
        for (int i = 0; i < 4; i++) tick();
`endif
        req = 4'b0000;
        tick();
        check("lock_idle_valid", {31'd0, out_valid}, 32'd0);

        // Single requester streaming at full throughput.
        req = 4'b0010;
        for (int i = 0; i < 4; i++) exp_push(1, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        req = 4'b0000;
        tick();
        check("stream_idle_valid", {31'd0, out_valid}, 32'd0);

        // Reset during HOLD drops the word, then requester 0 wins first.
        req = 4'b1111; out_ready = 1'b0;
        tick();
        check("pre_rst_select", {30'd0, select}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_select", {30'd0, select}, 32'd0);
        check("midrst_ack", {28'd0, ack}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_push(0, 1); exp_push(1, 2);
        tick();
        tick();
        req = 4'b0000;
        tick();
        tick();
        check("final_idle_valid", {31'd0, out_valid}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
